// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch (read-only) and the memory stage.
// One RAM transaction in flight at a time; MEM wins ties unless IF has been starved.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_re_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_busy_o,
  output logic              if_done_o,
  output logic [DATA_W-1:0] if_data_o,
  input  logic              mem_re_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [3:0]        mem_sel_i,
  output logic              mem_busy_o,
  output logic              mem_done_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic [3:0]        ram_sel_o,
  input  logic              ram_ack_i,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              err_o
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_ACC  = 2'd1,
    MEM_ACC = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic             grant_if;
  logic             grant_mem;
  logic             ack_if;
  logic             ack_mem;
  logic             stray_ack;
  logic             mem_req;

  logic [CNT_W-1:0]  starve_q;
  logic              busy_q;
  logic              ram_req_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [3:0]        ram_sel_q;
  logic              if_done_q;
  logic              mem_done_q;
  logic [DATA_W-1:0] if_data_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              err_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: arbitration in IDLE, wait for the RAM ack in either access state
  always_comb begin
    state_d   = state_q;
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    ack_if    = 1'b0;
    ack_mem   = 1'b0;
    stray_ack = 1'b0;
    mem_req   = mem_re_i | mem_we_i;
    case (state_q)
      IDLE: begin
        stray_ack = ram_ack_i;
        if (if_re_i && ((starve_q == CNT_MAX) || !mem_req)) begin
          grant_if = 1'b1;
          state_d  = IF_ACC;
        end else if (mem_req) begin
          grant_mem = 1'b1;
          state_d   = MEM_ACC;
        end
      end
      IF_ACC: begin
        if (ram_ack_i) begin
          ack_if  = 1'b1;
          state_d = IDLE;
        end
      end
      MEM_ACC: begin
        if (ram_ack_i) begin
          ack_mem = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM-side request registers, held stable for the whole access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_sel_q   <= 4'h0;
    end else begin
      busy_q    <= (state_d != IDLE);
      ram_req_q <= (state_d != IDLE);
      if (grant_if) begin
        ram_we_q    <= 1'b0;
        ram_addr_q  <= if_addr_i;
        ram_wdata_q <= '0;
        ram_sel_q   <= 4'hF;
      end else if (grant_mem) begin
        ram_we_q    <= mem_we_i;
        ram_addr_q  <= mem_addr_i;
        ram_wdata_q <= mem_wdata_i;
        ram_sel_q   <= mem_sel_i;
      end
    end
  end

  // Starvation counter: counts MEM grants that IF sat through
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (grant_if) begin
      starve_q <= '0;
    end else if (grant_mem) begin
      if (!if_re_i) begin
        starve_q <= '0;
      end else if (starve_q != CNT_MAX) begin
        starve_q <= starve_q + CNT_W'(1);
      end
    end
  end

  // Requester-side completion pulses and held read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      if_done_q  <= ack_if;
      mem_done_q <= ack_mem;
      if (ack_if) begin
        if_data_q <= ram_rdata_i;
      end
      if (ack_mem && !ram_we_q) begin
        mem_rdata_q <= ram_rdata_i;
      end
    end
  end

  // Sticky protocol error: RAM acknowledged with nothing outstanding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (stray_ack) begin
      err_q <= 1'b1;
    end
  end

  assign if_busy_o   = busy_q;
  assign mem_busy_o  = busy_q;
  assign if_done_o   = if_done_q;
  assign if_data_o   = if_data_q;
  assign mem_done_o  = mem_done_q;
  assign mem_rdata_o = mem_rdata_q;
  assign ram_req_o   = ram_req_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign ram_sel_o   = ram_sel_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against
// a transaction-level model of the arbitration rules; a small bench-side RAM answers requests.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned DATA_W       = 32;
  localparam int          STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_re_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_busy_o;
  logic              if_done_o;
  logic [DATA_W-1:0] if_data_o;
  logic              mem_re_i;
  logic              mem_we_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic [3:0]        mem_sel_i;
  logic              mem_busy_o;
  logic              mem_done_o;
  logic [DATA_W-1:0] mem_rdata_o;
  logic              ram_req_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_wdata_o;
  logic [3:0]        ram_sel_o;
  logic              ram_ack_i;
  logic [DATA_W-1:0] ram_rdata_i;
  logic              err_o;

  mem_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_re_i    (if_re_i),
    .if_addr_i  (if_addr_i),
    .if_busy_o  (if_busy_o),
    .if_done_o  (if_done_o),
    .if_data_o  (if_data_o),
    .mem_re_i   (mem_re_i),
    .mem_we_i   (mem_we_i),
    .mem_addr_i (mem_addr_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_sel_i  (mem_sel_i),
    .mem_busy_o (mem_busy_o),
    .mem_done_o (mem_done_o),
    .mem_rdata_o(mem_rdata_o),
    .ram_req_o  (ram_req_o),
    .ram_we_o   (ram_we_o),
    .ram_addr_o (ram_addr_o),
    .ram_wdata_o(ram_wdata_o),
    .ram_sel_o  (ram_sel_o),
    .ram_ack_i  (ram_ack_i),
    .ram_rdata_i(ram_rdata_i),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit auto_ack = 1'b0;

  // Transaction-level expectation of the port
  bit              m_busy;
  bit              m_owner_mem;
  bit              m_we;
  bit [ADDR_W-1:0] m_addr;
  bit [DATA_W-1:0] m_wdata;
  bit [3:0]        m_sel;
  int              m_starve;
  bit              m_if_done;
  bit              m_mem_done;
  bit [DATA_W-1:0] m_if_data;
  bit [DATA_W-1:0] m_mem_rdata;
  bit              m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner_mem = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_sel = '0;
    m_starve = 0; m_if_done = 0; m_mem_done = 0; m_if_data = '0; m_mem_rdata = '0; m_err = 0;
  endtask

  // One clock of the arbitration rules, applied to the inputs present before the edge
  task automatic model_step();
    bit mreq;
    m_if_done  = 0;
    m_mem_done = 0;
    mreq = mem_re_i | mem_we_i;
    if (!m_busy) begin
      if (ram_ack_i) m_err = 1;
      if (if_re_i && (m_starve == STARVE_LIMIT || !mreq)) begin
        m_busy = 1; m_owner_mem = 0; m_we = 0; m_addr = if_addr_i; m_sel = 4'hF;
        m_starve = 0;
      end else if (mreq) begin
        m_busy = 1; m_owner_mem = 1; m_we = mem_we_i; m_addr = mem_addr_i;
        m_wdata = mem_wdata_i; m_sel = mem_sel_i;
        m_starve = if_re_i ? ((m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT) : 0;
      end
    end else if (ram_ack_i) begin
      m_busy = 0;
      if (m_owner_mem) begin
        m_mem_done = 1;
        if (!m_we) m_mem_rdata = ram_rdata_i;
      end else begin
        m_if_done = 1;
        m_if_data = ram_rdata_i;
      end
    end
  endtask

  task automatic check_all();
    chk("ram_req", 64'(ram_req_o), 64'(m_busy));
    chk("if_busy", 64'(if_busy_o), 64'(m_busy));
    chk("mem_busy", 64'(mem_busy_o), 64'(m_busy));
    chk("if_done", 64'(if_done_o), 64'(m_if_done));
    chk("mem_done", 64'(mem_done_o), 64'(m_mem_done));
    chk("if_data", 64'(if_data_o), 64'(m_if_data));
    chk("mem_rdata", 64'(mem_rdata_o), 64'(m_mem_rdata));
    chk("err", 64'(err_o), 64'(m_err));
    if (m_busy) begin
      chk("ram_addr", 64'(ram_addr_o), 64'(m_addr));
      chk("ram_we", 64'(ram_we_o), 64'(m_we));
      chk("ram_sel", 64'(ram_sel_o), 64'(m_sel));
      if (m_we) chk("ram_wdata", 64'(ram_wdata_o), 64'(m_wdata));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    if (auto_ack) begin
      ram_ack_i   = ram_req_o && ($urandom_range(0, 1) == 1);
      ram_rdata_i = $urandom;
    end
  endtask

  initial begin
    string pattern;
    string seen;
    bit    prev_req;
    int    grants;

    rst_n = 0; if_re_i = 0; if_addr_i = '0; mem_re_i = 0; mem_we_i = 0;
    mem_addr_i = '0; mem_wdata_i = '0; mem_sel_i = '0; ram_ack_i = 0; ram_rdata_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_ram_sel", 64'(ram_sel_o), 64'h0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // IF-only fetch: request in cycle 0, ack two cycles after req rises
    if_re_i = 1; if_addr_i = 32'h100;
    tick();
    chk("t1_req_c1", 64'(ram_req_o), 64'h1);
    chk("t1_addr", 64'(ram_addr_o), 64'h100);
    chk("t1_sel", 64'(ram_sel_o), 64'hF);
    if_re_i = 0;
    tick();
    chk("t1_req_c2", 64'(ram_req_o), 64'h1);
    tick();
    chk("t1_req_c3", 64'(ram_req_o), 64'h1);
    chk("t1_busy_c3", 64'(if_busy_o), 64'h1);
    ram_ack_i = 1; ram_rdata_i = 32'hCAFE0001;
    tick();
    ram_ack_i = 0;
    chk("t1_done_c4", 64'(if_done_o), 64'h1);
    chk("t1_data", 64'(if_data_o), 64'hCAFE0001);
    chk("t1_req_c4", 64'(ram_req_o), 64'h0);
    chk("t1_busy_c4", 64'(if_busy_o), 64'h0);
    tick();
    chk("t1_done_pulse", 64'(if_done_o), 64'h0);

    // Simultaneous IF and MEM read: MEM first, IF keeps requesting and follows
    if_re_i = 1; if_addr_i = 32'h200; mem_re_i = 1; mem_addr_i = 32'h300;
    tick();
    chk("t2_mem_first", 64'(ram_addr_o), 64'h300);
    mem_re_i = 0;
    tick();
    ram_ack_i = 1; ram_rdata_i = 32'h5555AAAA;
    tick();
    ram_ack_i = 0;
    chk("t2_mem_done", 64'(mem_done_o), 64'h1);
    chk("t2_mem_rdata", 64'(mem_rdata_o), 64'h5555AAAA);
    tick();
    chk("t2_if_next", 64'(ram_addr_o), 64'h200);
    if_re_i = 0;
    ram_ack_i = 1; ram_rdata_i = 32'h0BADF00D;
    tick();
    ram_ack_i = 0;
    chk("t2_if_done", 64'(if_done_o), 64'h1);
    chk("t2_if_data", 64'(if_data_o), 64'h0BADF00D);

    // MEM write with re also high: write wins, read data register untouched
    mem_we_i = 1; mem_re_i = 1; mem_addr_i = 32'h20; mem_wdata_i = 32'hDEADBEEF; mem_sel_i = 4'b0011;
    tick();
    chk("t3_we", 64'(ram_we_o), 64'h1);
    chk("t3_sel", 64'(ram_sel_o), 64'h3);
    chk("t3_wdata", 64'(ram_wdata_o), 64'hDEADBEEF);
    chk("t3_addr", 64'(ram_addr_o), 64'h20);
    mem_we_i = 0; mem_re_i = 0;
    ram_ack_i = 1; ram_rdata_i = 32'h12345678;
    tick();
    ram_ack_i = 0;
    chk("t3_done", 64'(mem_done_o), 64'h1);
    chk("t3_rdata_kept", 64'(mem_rdata_o), 64'h5555AAAA);

    // Both requesting continuously: grant order must follow the starvation guard
    if_re_i = 1; if_addr_i = 32'h400; mem_re_i = 1; mem_addr_i = 32'h500; mem_sel_i = 4'hF;
    auto_ack = 1;
    pattern = "MMMMIMMMMI";
    seen = "";
    prev_req = ram_req_o;
    grants = 0;
    for (int c = 0; c < 300 && grants < 10; c++) begin
      tick();
      if (ram_req_o && !prev_req) begin
        seen = {seen, (ram_addr_o == 32'h400) ? "I" : "M"};
        grants++;
      end
      prev_req = ram_req_o;
    end
    chk("t4_grant_count", 64'(grants), 64'd10);
    for (int g = 0; g < 10; g++) begin
      if (g < seen.len()) chk($sformatf("t4_grant%0d", g), 64'(seen[g]), 64'(pattern[g]));
    end
    if_re_i = 0; mem_re_i = 0;
    for (int c = 0; c < 50 && m_busy; c++) tick();
    chk("t4_drained", 64'(m_busy), 64'h0);

    // Randomized traffic with random RAM latency and data
    for (int c = 0; c < 600; c++) begin
      if_re_i     = ($urandom_range(0, 1) == 1);
      if_addr_i   = $urandom;
      mem_re_i    = ($urandom_range(0, 2) == 0);
      mem_we_i    = ($urandom_range(0, 3) == 0);
      mem_addr_i  = $urandom;
      mem_wdata_i = $urandom;
      mem_sel_i   = 4'($urandom_range(0, 15));
      tick();
    end
    if_re_i = 0; mem_re_i = 0; mem_we_i = 0;
    for (int c = 0; c < 50 && m_busy; c++) tick();
    chk("rand_drained", 64'(m_busy), 64'h0);
    auto_ack = 0;
    ram_ack_i = 0;

    // Reset in the middle of a MEM access: request drops at once, no completion
    mem_re_i = 1; mem_addr_i = 32'h40;
    tick();
    mem_re_i = 0;
    chk("t5_req_before", 64'(ram_req_o), 64'h1);
    #2;
    rst_n = 0;
    #1;
    chk("t5_req_async", 64'(ram_req_o), 64'h0);
    chk("t5_busy_async", 64'(mem_busy_o), 64'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    check_all();
    repeat (3) begin
      tick();
      chk("t5_no_done", 64'(mem_done_o), 64'h0);
    end

    // Stray ack while idle: ignored but flagged until reset
    ram_ack_i = 1; ram_rdata_i = 32'hFFFF0000;
    tick();
    ram_ack_i = 0;
    chk("t6_err_set", 64'(err_o), 64'h1);
    chk("t6_no_if_done", 64'(if_done_o), 64'h0);
    chk("t6_no_mem_done", 64'(mem_done_o), 64'h0);
    repeat (2) tick();
    chk("t6_err_sticky", 64'(err_o), 64'h1);
    #2;
    rst_n = 0;
    #1;
    chk("t6_err_cleared", 64'(err_o), 64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
